// File: rtl/disp_scan_ctrl.sv
// Round-robin scanner that time-shares one 4-bit seven-segment decoder among
// NUM_CH result channels, with freeze (hold) and single-step for board debug.
module disp_scan_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int DWELL_CYC = 1000,
    parameter int CW        = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NUM_CH-1:0] ch_data,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                hold,
    input  logic                step,
    output logic [3:0]          disp_val,
    output logic [CW-1:0]       disp_ch,
    output logic [NUM_CH-1:0]   disp_oh,
    output logic                blank,
    output logic                adv
);

    localparam int CNTW = $clog2(DWELL_CYC);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [CW-1:0]     r_ch;
    logic [3:0]        r_val;
    logic [NUM_CH-1:0] r_oh;
    logic              r_blank;
    logic              r_adv;

    state_t            w_state_nxt;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic [CW-1:0]     w_ch_nxt;
    logic              w_blank_nxt;
    logic              w_adv_nxt;
    logic [CW-1:0]     w_ch_rr;
    logic [CW-1:0]     w_ch_low;

    // First enabled index scanning c+1, c+2, ... with wrap; may return c itself.
    function automatic logic [CW-1:0] f_nxt(input logic [CW-1:0]     c,
                                            input logic [NUM_CH-1:0] en);
        logic [CW-1:0] res;
        logic [CW:0]   idx;
        logic          found;
        res   = c;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = {1'b0, c} + (CW+1)'(k);
            if (idx >= (CW+1)'(NUM_CH))
                idx = idx - (CW+1)'(NUM_CH);
            if (!found && en[idx[CW-1:0]]) begin
                res   = idx[CW-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_ch_rr  = f_nxt(r_ch, ch_en);
    // Scanning from the top index wraps to 0 first, yielding the lowest enabled.
    assign w_ch_low = f_nxt(CW'(NUM_CH - 1), ch_en);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_blank_nxt = 1'b0;
        w_adv_nxt   = 1'b0;
        if (ch_en == '0) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_blank_nxt = 1'b1;
        end else if (r_state == ST_BLANK) begin
            w_state_nxt = ST_SHOW;
            w_ch_nxt    = w_ch_low;
            w_cnt_nxt   = '0;
            w_adv_nxt   = 1'b1;
        end else if (!ch_en[r_ch]) begin
            w_ch_nxt  = w_ch_rr;
            w_cnt_nxt = '0;
            w_adv_nxt = 1'b1;
        end else if (hold) begin
            w_state_nxt = ST_HOLD;
            if (step) begin
                w_ch_nxt  = w_ch_rr;
                w_cnt_nxt = '0;
                w_adv_nxt = (w_ch_rr != r_ch);
            end
        end else begin
            // Releasing hold resumes counting on the same cycle as SHOW would.
            w_state_nxt = ST_SHOW;
            if (r_cnt == CNTW'(DWELL_CYC - 1)) begin
                w_ch_nxt  = w_ch_rr;
                w_cnt_nxt = '0;
                w_adv_nxt = (w_ch_rr != r_ch);
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_val   <= '0;
            r_oh    <= '0;
            r_blank <= 1'b1;
            r_adv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ch    <= w_ch_nxt;
            r_blank <= w_blank_nxt;
            r_adv   <= w_adv_nxt;
            // Data follows the post-edge channel so a switch and its value coincide.
            r_val   <= w_blank_nxt ? 4'd0 : ch_data[{w_ch_nxt, 2'b00} +: 4];
            r_oh    <= w_blank_nxt ? '0 : (NUM_CH'(1) << w_ch_nxt);
        end
    end

    assign disp_val = r_val;
    assign disp_ch  = r_ch;
    assign disp_oh  = r_oh;
    assign blank    = r_blank;
    assign adv      = r_adv;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a behavioural model pushes the expected
// outputs per clock; each test pops and compares them, plus fixed-value checks.
module tb_disp_scan_ctrl;

    localparam int NUM_CH = 4;
    localparam int DWELL  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ch_data;
    logic [3:0]  ch_en;
    logic        hold;
    logic        step;
    logic [3:0]  disp_val;
    logic [1:0]  disp_ch;
    logic [3:0]  disp_oh;
    logic        blank;
    logic        adv;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.NUM_CH(NUM_CH), .DWELL_CYC(DWELL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_data  (ch_data),
        .ch_en    (ch_en),
        .hold     (hold),
        .step     (step),
        .disp_val (disp_val),
        .disp_ch  (disp_ch),
        .disp_oh  (disp_oh),
        .blank    (blank),
        .adv      (adv)
    );

    typedef struct packed {
        logic       blank;
        logic       adv;
        logic [3:0] oh;
        logic [1:0] ch;
        logic [3:0] val;
    } obs_t;

    obs_t exp_q[$];
    obs_t e;
    obs_t got;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_st   = 0;   // 0 blank, 1 show, 2 hold
    int   m_ch   = 0;
    int   m_cnt  = 0;

    function automatic int nxt_ch(input int c, input logic [3:0] en);
        int i;
        i = c;
        for (int k = 0; k < NUM_CH; k++) begin
            i = (i + 1) % NUM_CH;
            if (en[i[1:0]]) return i;
        end
        return c;
    endfunction

    // Advance the model by one clock, queue its prediction, then step the DUT.
    task automatic cyc();
        obs_t x;
        int   old;
        x.adv   = 1'b0;
        x.blank = 1'b0;
        old     = m_ch;
        if (!rst_n) begin
            m_st = 0; m_ch = 0; m_cnt = 0; x.blank = 1'b1;
        end else if (ch_en == 4'b0) begin
            m_st = 0; m_cnt = 0; x.blank = 1'b1;
        end else if (m_st == 0) begin
            m_st = 1; m_ch = nxt_ch(NUM_CH - 1, ch_en); m_cnt = 0; x.adv = 1'b1;
        end else if (!ch_en[m_ch[1:0]]) begin
            m_ch = nxt_ch(m_ch, ch_en); m_cnt = 0; x.adv = 1'b1;
        end else if (hold) begin
            m_st = 2;
            if (step) begin
                m_ch = nxt_ch(m_ch, ch_en); m_cnt = 0; x.adv = (old != m_ch);
            end
        end else begin
            m_st = 1;
            if (m_cnt == DWELL - 1) begin
                m_ch = nxt_ch(m_ch, ch_en); m_cnt = 0; x.adv = (old != m_ch);
            end else begin
                m_cnt++;
            end
        end
        x.ch  = m_ch[1:0];
        x.oh  = x.blank ? 4'b0 : (4'b1 << m_ch[1:0]);
        x.val = x.blank ? 4'b0 : ch_data[{m_ch[1:0], 2'b00} +: 4];
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_en = 4'b0; hold = 1'b0; step = 1'b0; ch_data = 16'hF385;
        for (int i = 0; i < 2; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_sb cyc%0d: got %h expected %h", i, got, e);
            end
        end
        n_chk++;
        if ({blank, adv, disp_oh, disp_ch, disp_val} !== {1'b1, 1'b0, 4'b0, 2'b0, 4'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got %b_%b_%b_%b_%h expected 1_0_0000_00_0",
                     blank, adv, disp_oh, disp_ch, disp_val);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] seq [5];
        int k;
        int last;
        seq = '{4'h5, 4'h8, 4'h3, 4'hF, 4'h5};
        k = 0; last = 0;
        rst_n = 1'b1; ch_en = 4'b1111;
        for (int i = 1; i <= 17; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rotate_sb cyc%0d: got %h expected %h", i, got, e);
            end
            if (adv === 1'b1 && k < 5) begin
                n_chk++;
                if (disp_val !== seq[k] || (k > 0 && i - last != DWELL)) begin
                    n_fail++;
                    $display("FAIL rotate_seq #%0d: got val %h gap %0d expected val %h gap %0d",
                             k, disp_val, i - last, seq[k], DWELL);
                end
                k++; last = i;
            end
        end
        n_chk++;
        if (k != 5) begin
            n_fail++;
            $display("FAIL rotate_adv_count: got %0d expected 5", k);
        end
    endtask

    task automatic test_two_channels();
        ch_en = 4'b1010;
        for (int i = 0; i < 13; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL two_sb cyc%0d: got %h expected %h", i, got, e);
            end
            n_chk++;
            if (!((disp_ch === 2'd1 && disp_oh === 4'b0010) ||
                  (disp_ch === 2'd3 && disp_oh === 4'b1000))) begin
                n_fail++;
                $display("FAIL two_chan cyc%0d: got ch %0d oh %b expected ch 1/3 oh 0010/1000",
                         i, disp_ch, disp_oh);
            end
        end
    endtask

    task automatic test_single_then_blank();
        ch_en = 4'b0100;
        for (int i = 0; i < 13; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL single_sb cyc%0d: got %h expected %h", i, got, e);
            end
            if (i > 0) begin
                n_chk++;
                if (disp_ch !== 2'd2 || adv !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_hold cyc%0d: got ch %0d adv %b expected ch 2 adv 0",
                             i, disp_ch, adv);
                end
            end
        end
        ch_en = 4'b0;
        cyc();
        got = {blank, adv, disp_oh, disp_ch, disp_val};
        e   = exp_q.pop_front();
        n_chk++;
        if (got !== e || blank !== 1'b1 || disp_val !== 4'd0 || disp_oh !== 4'd0) begin
            n_fail++;
            $display("FAIL blank: got %h expected %h (blank=1 val=0 oh=0)", got, e);
        end
    endtask

    task automatic test_hold_step();
        int adv_at;
        ch_en = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL hold_pre_sb cyc%0d: got %h expected %h", i, got, e);
            end
        end
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e || disp_ch !== 2'd0 || adv !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_frozen cyc%0d: got %h expected %h", i, got, e);
            end
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        got = {blank, adv, disp_oh, disp_ch, disp_val};
        e   = exp_q.pop_front();
        n_chk++;
        if (got !== e || disp_ch !== 2'd1 || adv !== 1'b1) begin
            n_fail++;
            $display("FAIL step: got %h expected %h (ch 1 adv 1)", got, e);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e || disp_ch !== 2'd1) begin
                n_fail++;
                $display("FAIL step_once cyc%0d: got %h expected %h", i, got, e);
            end
        end
        hold = 1'b0;
        adv_at = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL resume_sb cyc%0d: got %h expected %h", i, got, e);
            end
            if (adv === 1'b1 && adv_at == 0) adv_at = i;
        end
        n_chk++;
        if (adv_at != DWELL) begin
            n_fail++;
            $display("FAIL resume_gap: got advance at %0d expected %0d", adv_at, DWELL);
        end
    endtask

    task automatic test_drop_current();
        int n;
        int adv_at;
        n = 0;
        while (disp_ch !== 2'd1 && n < 20) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL drop_wait_sb: got %h expected %h", got, e);
            end
            n++;
        end
        n_chk++;
        if (disp_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL drop_wait_timeout: got ch %0d expected 1", disp_ch);
        end
        ch_en = 4'b1101;
        cyc();
        got = {blank, adv, disp_oh, disp_ch, disp_val};
        e   = exp_q.pop_front();
        n_chk++;
        if (got !== e || disp_ch !== 2'd2 || adv !== 1'b1 || disp_val !== 4'h3) begin
            n_fail++;
            $display("FAIL drop: got %h expected %h (ch 2 adv 1 val 3)", got, e);
        end
        adv_at = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            got = {blank, adv, disp_oh, disp_ch, disp_val};
            e   = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL drop_after_sb cyc%0d: got %h expected %h", i, got, e);
            end
            if (adv === 1'b1 && adv_at == 0) adv_at = i;
        end
        n_chk++;
        if (adv_at != DWELL) begin
            n_fail++;
            $display("FAIL drop_cnt_cleared: got advance at %0d expected %0d", adv_at, DWELL);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ch_en = 4'b1111;
        n = 0;
        while (disp_ch !== 2'd3 && n < 20) begin
            cyc();
            void'(exp_q.pop_front());
            n++;
        end
        cyc();
        got = {blank, adv, disp_oh, disp_ch, disp_val};
        e   = exp_q.pop_front();
        n_chk++;
        if (got !== e || disp_ch !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_dwell: got %h expected %h (ch 3)", got, e);
        end
        rst_n = 1'b0;
        cyc();
        got = {blank, adv, disp_oh, disp_ch, disp_val};
        e   = exp_q.pop_front();
        n_chk++;
        if (got !== e || got !== {1'b1, 1'b0, 4'b0, 2'b0, 4'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h expected %h", got, e);
        end
        rst_n = 1'b1; ch_en = 4'b1000;
        cyc();
        got = {blank, adv, disp_oh, disp_ch, disp_val};
        e   = exp_q.pop_front();
        n_chk++;
        if (got !== e || disp_ch !== 2'd3 || blank !== 1'b0 || disp_val !== 4'hF) begin
            n_fail++;
            $display("FAIL release: got %h expected %h (ch 3 blank 0 val F)", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_two_channels();
        test_single_then_blank();
        test_hold_step();
        test_drop_current();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
